// File: rtl/maze_move_arbiter.sv
// Merges keyboard and autoplay-solver maze moves onto one valid/ready move port.
// Define MOVE_REPEAT_EN to build the typematic auto-repeat (HOLD state + repeat counter).
`timescale 1ns/1ps
module maze_move_arbiter #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned IDLE_CYCLES   = 250_000_000,
    parameter int unsigned CNT_W         = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       key_break,
    input  logic       auto_valid,
    input  logic [1:0] auto_code,
    output logic       auto_ready,
    output logic       mv_valid,
    output logic [1:0] mv_code,
    output logic       mv_src,
    input  logic       mv_ready,
    output logic       auto_mode
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
`ifdef MOVE_REPEAT_EN
    localparam logic [1:0] S_HOLD  = 2'd2;
`endif
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);

    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0 ||
        (CNT_W < 32 && IDLE_CYCLES >= (32'd1 << CNT_W))) begin : g_bad_cfg
        $error("maze_move_arbiter: invalid timing parameters");
    end

    logic [1:0]       state_q, state_d;
    logic [1:0]       held_q, held_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0]       code_q, code_d;
    logic             src_q, src_d;
    logic             auto_mode_q, auto_mode_d;
    logic [CNT_W-1:0] idle_q, idle_d;
`ifdef MOVE_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             first_q, first_d;
`endif

    logic       key_make, key_brk, xfer, auto_acc;
    logic [1:0] pend_eff;

    always_comb begin
        key_make   = key_valid & ~key_break & (key_code != 2'd0);
        key_brk    = key_valid & key_break;
        auto_ready = auto_mode_q & (state_q == S_IDLE) & ~key_valid;
        auto_acc   = auto_valid & auto_ready;
        mv_valid   = (state_q == S_ISSUE);
        xfer       = mv_valid & mv_ready;
        // A make landing on the transfer cycle must not be lost, so it bypasses pending_q.
        pend_eff   = key_make ? key_code : pending_q;
        mv_code    = code_q;
        mv_src     = src_q;
        auto_mode  = auto_mode_q;
    end

    always_comb begin
        held_d      = held_q;
        idle_d      = idle_q;
        auto_mode_d = auto_mode_q;

        if (key_make)
            held_d = key_code;
        else if (key_brk && key_code == held_q)
            held_d = 2'd0;

        if (key_make || key_brk)
            idle_d = '0;
        else if (!key_valid && !auto_mode_q && held_q == 2'd0 && idle_q != IDLE_LIM)
            idle_d = idle_q + CNT_W'(1);

        if (key_make)
            auto_mode_d = 1'b0;
        else if (idle_q == IDLE_LIM)
            auto_mode_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        code_d    = code_q;
        src_d     = src_q;
`ifdef MOVE_REPEAT_EN
        rep_d     = rep_q;
        first_d   = first_q;
`endif
        case (state_q)
            S_ISSUE: begin
                if (key_make)
                    pending_d = key_code;
                if (xfer) begin
                    if (pend_eff != 2'd0) begin
                        code_d    = pend_eff;
                        src_d     = 1'b0;
                        pending_d = 2'd0;
`ifdef MOVE_REPEAT_EN
                        first_d   = 1'b1;
`endif
                    end
`ifdef MOVE_REPEAT_EN
                    else if (!src_q && held_d == code_q) begin
                        state_d = S_HOLD;
                        rep_d   = first_q ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
                        first_d = 1'b0;
                    end
`endif
                    else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef MOVE_REPEAT_EN
            S_HOLD: begin
                if (key_make) begin
                    state_d = S_ISSUE;
                    code_d  = key_code;
                    src_d   = 1'b0;
                    first_d = 1'b1;
                end else if (held_d == 2'd0) begin
                    state_d = S_IDLE;
                end else if (rep_q == '0) begin
                    state_d = S_ISSUE;
                    code_d  = held_q;
                    src_d   = 1'b0;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                if (key_make) begin
                    state_d = S_ISSUE;
                    code_d  = key_code;
                    src_d   = 1'b0;
`ifdef MOVE_REPEAT_EN
                    first_d = 1'b1;
`endif
                end else if (auto_acc) begin
                    state_d = S_ISSUE;
                    code_d  = auto_code;
                    src_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            held_q      <= 2'd0;
            pending_q   <= 2'd0;
            code_q      <= 2'd0;
            src_q       <= 1'b0;
            auto_mode_q <= 1'b0;
            idle_q      <= '0;
`ifdef MOVE_REPEAT_EN
            rep_q       <= '0;
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            pending_q   <= pending_d;
            code_q      <= code_d;
            src_q       <= src_d;
            auto_mode_q <= auto_mode_d;
            idle_q      <= idle_d;
`ifdef MOVE_REPEAT_EN
            rep_q       <= rep_d;
            first_q     <= first_d;
`endif
        end
    end

endmodule
